// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Shares the register-file write port between pipeline write-back
//            (A) and a long-latency unit (B); tracks B-owned destinations.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
   parameter int N        = 32,
   parameter int MAX_WAIT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         iss_valid,
   input  logic         iss_long,
   input  logic [4:0]   iss_rd,
   input  logic [4:0]   iss_rs1,
   input  logic [4:0]   iss_rs2,
   output logic         hazard,
   input  logic         a_valid,
   input  logic [4:0]   a_rd,
   input  logic [N-1:0] a_data,
   output logic         stall_a,
   input  logic         b_valid,
   input  logic [4:0]   b_rd,
   input  logic [N-1:0] b_data,
   output logic         b_ready,
   output logic         rf_write,
   output logic [4:0]   rf_waddr,
   output logic [N-1:0] rf_wdata
);

   localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [3:0]     r_wait_cnt, w_wait_cnt_nxt;
   logic [31:0]    r_pending, w_pending_nxt;
   logic           r_rf_write;
   logic [4:0]     r_rf_waddr;
   logic [N-1:0]   r_rf_wdata;
   logic           r_rf_from_b;
   logic           w_a_req;
   logic           w_grant_a;
   logic           w_grant_b;
   logic           w_stall;
   logic           w_b_ready;
   logic           w_hazard;
   logic           w_iss_set;

   // Arbitration: B loses at most MAX_WAIT+1 times before A is stalled for one cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_grant_a      = 1'b0;
      w_grant_b      = 1'b0;
      w_stall        = 1'b0;
      w_b_ready      = 1'b0;
      w_a_req        = a_valid & (a_rd != 5'd0);
      case (r_state)
         ST_IDLE: begin
            if (w_a_req) begin
               w_grant_a = 1'b1;
               if (b_valid) begin
                  w_wait_cnt_nxt = 4'd1;
                  w_state_nxt    = ST_WAIT;
               end
            end else if (b_valid) begin
               w_grant_b = 1'b1;
               w_b_ready = 1'b1;
            end
         end
         ST_WAIT: begin
            if (!b_valid) begin
               w_grant_a      = w_a_req;
               w_wait_cnt_nxt = 4'd0;
               w_state_nxt    = ST_IDLE;
            end else if (!w_a_req) begin
               w_grant_b      = 1'b1;
               w_b_ready      = 1'b1;
               w_wait_cnt_nxt = 4'd0;
               w_state_nxt    = ST_IDLE;
            end else if (r_wait_cnt == C_MAX_WAIT) begin
               w_grant_a   = 1'b1;
               w_state_nxt = ST_FORCE;
            end else begin
               w_grant_a      = 1'b1;
               w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            end
         end
         ST_FORCE: begin
            w_stall        = 1'b1;
            w_b_ready      = 1'b1;
            w_grant_b      = b_valid;
            w_wait_cnt_nxt = 4'd0;
            w_state_nxt    = ST_IDLE;
         end
         default: begin
            w_wait_cnt_nxt = 4'd0;
            w_state_nxt    = ST_IDLE;
         end
      endcase
      if (rst) begin
         w_grant_a = 1'b0;
         w_grant_b = 1'b0;
         w_stall   = 1'b0;
         w_b_ready = 1'b0;
      end
   end

   // Hazard looks only at registered pending bits: no forwarding of same-cycle clears.
   always_comb begin
      w_hazard  = ~rst & iss_valid &
                  (r_pending[iss_rs1] | r_pending[iss_rs2] | r_pending[iss_rd]);
      w_iss_set = iss_valid & iss_long & ~w_hazard & (iss_rd != 5'd0);
      w_pending_nxt = r_pending;
      if (r_rf_write & r_rf_from_b)
         w_pending_nxt[r_rf_waddr] = 1'b0;
      if (w_iss_set)
         w_pending_nxt[iss_rd] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_wait_cnt  <= 4'd0;
         r_pending   <= 32'd0;
         r_rf_write  <= 1'b0;
         r_rf_waddr  <= 5'd0;
         r_rf_wdata  <= '0;
         r_rf_from_b <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_pending  <= w_pending_nxt;
         if (w_grant_a) begin
            r_rf_write  <= 1'b1;
            r_rf_waddr  <= a_rd;
            r_rf_wdata  <= a_data;
            r_rf_from_b <= 1'b0;
         end else if (w_grant_b && (b_rd != 5'd0)) begin
            r_rf_write  <= 1'b1;
            r_rf_waddr  <= b_rd;
            r_rf_wdata  <= b_data;
            r_rf_from_b <= 1'b1;
         end else begin
            r_rf_write  <= 1'b0;
            r_rf_from_b <= 1'b0;
         end
      end
   end

   assign hazard   = w_hazard;
   assign stall_a  = w_stall;
   assign b_ready  = w_b_ready;
   assign rf_write = r_rf_write;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;

endmodule
`default_nettype wire
